matrix_scan_controller: RTL and testbench

- Sequences the 5-column LED matrix scan: one-hot column drive, per-column row data, blanking between columns and a fixed dwell per column.
- Uses the mirrored-image property: columns 4/0 and 3/1 share row data, so an image is only 3 column patterns.
- Accepts new images over a valid/ready handshake and swaps them only at frame boundaries, so no partial frame is ever shown.
- Sits between the irrigation status logic (image source) and the matrix pins.

---
 rtl/matrix_scan_controller.sv | 138 +++++++++++++
 tb/tb_matrix_scan_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_controller.sv
// Purpose: scans a 5-column LED matrix (one-hot col, per-column row data, blanking + dwell per column)
//          from a 3-pattern mirrored image; new images are double-buffered and swapped at frame start.
// Latency: a transfer accepted in frame N is displayed from frame N+1 (N+2 if frame N was still draining).
// Backpressure: load_ready = pending buffer empty; a held load_valid waits until the next frame boundary frees it.
// Ports: clock/reset (async active-low), enable (0 blanks and parks the scan), pattern_in/load_valid/load_ready
//        (image load handshake), col (one-hot column), row (row data for driven column), frame_start (1-cycle pulse).
module matrix_scan_controller #(
  parameter int ROWS  = 7,
  parameter int DWELL = 1000,
  parameter int BLANK = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [3*ROWS-1:0]   pattern_in,
  input  logic                load_valid,
  output logic                load_ready,
  output logic [4:0]          col,
  output logic [ROWS-1:0]     row,
  output logic                frame_start
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  // Unreachable when BLANK=0 (blank state is never entered); kept in range anyway.
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  // Every column slot opens with blanking unless blanking is disabled.
  localparam state_t SLOT_FIRST = (BLANK > 0) ? S_BLANK : S_DRIVE;

  state_t            state, state_nx;
  logic [2:0]        idx, idx_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              boundary;
  logic [3*ROWS-1:0] active;
  logic [3*ROWS-1:0] pending;
  logic              pending_full;

  assign load_ready = !pending_full;

  // Next-state: enable=0 overrides everything and parks the scan at column 4.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt + 1'b1;
    boundary = 1'b0;
    if (!enable) begin
      state_nx = S_IDLE;
      idx_nx   = 3'd4;
      cnt_nx   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nx = SLOT_FIRST;
          idx_nx   = 3'd4;
          cnt_nx   = '0;
          boundary = 1'b1;
        end
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nx = S_DRIVE;
            cnt_nx   = '0;
          end
        end
        S_DRIVE: begin
          if (cnt == DWELL_LAST) begin
            state_nx = SLOT_FIRST;
            cnt_nx   = '0;
            if (idx == 3'd0) begin
              idx_nx   = 3'd4;
              boundary = 1'b1;
            end else begin
              idx_nx = idx - 3'd1;
            end
          end
        end
        default: begin
          state_nx = S_IDLE;
          idx_nx   = 3'd4;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      idx          <= 3'd4;
      cnt          <= '0;
      frame_start  <= 1'b0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      cnt         <= cnt_nx;
      frame_start <= boundary;
      // Swap and accept are mutually exclusive: accept needs pending empty,
      // swap needs it full. A load on a boundary edge with pending empty
      // therefore lands in pending and waits for the following frame.
      if (boundary && pending_full) begin
        active       <= pending;
        pending_full <= 1'b0;
      end
      if (load_valid && !pending_full) begin
        pending      <= pattern_in;
        pending_full <= 1'b1;
      end
    end
  end

  // Output decode from registered state: at most one column bit, and row
  // data only while a column is actually driven.
  always_comb begin
    col = '0;
    row = '0;
    if (state == S_DRIVE) begin
      case (idx)
        3'd4: begin col = 5'b10000; row = active[ROWS-1:0];        end
        3'd3: begin col = 5'b01000; row = active[2*ROWS-1:ROWS];   end
        3'd2: begin col = 5'b00100; row = active[3*ROWS-1:2*ROWS]; end
        3'd1: begin col = 5'b00010; row = active[2*ROWS-1:ROWS];   end
        3'd0: begin col = 5'b00001; row = active[ROWS-1:0];        end
        default: begin col = '0; row = '0; end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_controller.sv
module tb_matrix_scan_controller;

  localparam int ROWS = 7;
  localparam int DW   = 4;
  localparam int BL   = 2;
  localparam int SL   = DW + BL;
  localparam int FR   = 5 * SL;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [20:0] pattern_in;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  col;
  logic [6:0]  row;
  logic        frame_start;

  // Second instance: BLANK=0, DWELL=1, never loaded.
  logic [20:0] pattern_b = '0;
  logic        load_valid_b = 1'b0;
  logic        load_ready_b;
  logic [4:0]  col_b;
  logic [6:0]  row_b;
  logic        frame_start_b;

  int checks = 0;
  int errors = 0;

  // Reference model: scan position within the frame plus a one-deep image buffer.
  bit          m_run, m_pfull, m_xfer, m2_run;
  int          m_p, m2_p;
  logic [20:0] m_act, m_pend;

  always #5 clock = ~clock;

  matrix_scan_controller #(.ROWS(ROWS), .DWELL(DW), .BLANK(BL)) dut (
    .clock(clock), .reset(reset), .enable(enable), .pattern_in(pattern_in),
    .load_valid(load_valid), .load_ready(load_ready), .col(col), .row(row),
    .frame_start(frame_start)
  );

  matrix_scan_controller #(.ROWS(ROWS), .DWELL(1), .BLANK(0)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .pattern_in(pattern_b),
    .load_valid(load_valid_b), .load_ready(load_ready_b), .col(col_b), .row(row_b),
    .frame_start(frame_start_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] slice(input logic [20:0] a, input int cidx);
    if (cidx == 2)                 return a[20:14];
    else if (cidx == 1 || cidx == 3) return a[13:7];
    else                           return a[6:0];
  endfunction

  task automatic model_reset();
    m_run = 0; m_pfull = 0; m_xfer = 0; m_p = 0; m_act = '0; m_pend = '0;
    m2_run = 0; m2_p = 0;
  endtask

  task automatic compare_all();
    logic [4:0] ecol;
    logic [6:0] erow;
    logic       efs;
    int slot, w;
    ecol = '0; erow = '0; efs = 1'b0;
    if (m_run) begin
      slot = m_p / SL;
      w    = m_p % SL;
      if (w >= BL) begin
        ecol = 5'b10000 >> slot;
        erow = slice(m_act, 4 - slot);
      end
      efs = (m_p == 0);
    end
    check("col", {27'd0, col}, {27'd0, ecol});
    check("row", {25'd0, row}, {25'd0, erow});
    check("frame_start", {31'd0, frame_start}, {31'd0, efs});
    check("load_ready", {31'd0, load_ready}, {31'd0, !m_pfull});
    check("b_col", {27'd0, col_b}, m2_run ? {27'd0, 5'b10000 >> m2_p} : 32'd0);
    check("b_frame_start", {31'd0, frame_start_b}, {31'd0, m2_run && m2_p == 0});
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    bit bnd, xf;
    @(posedge clock);
    if (!reset) begin
      model_reset();
    end else begin
      xf  = load_valid && !m_pfull;
      bnd = 0;
      if (!enable) m_run = 0;
      else if (!m_run) begin m_run = 1; m_p = 0; bnd = 1; end
      else begin m_p = (m_p + 1) % FR; bnd = (m_p == 0); end
      if (bnd && m_pfull) begin m_act = m_pend; m_pfull = 0; end
      if (xf) begin m_pend = pattern_in; m_pfull = 1; end
      m_xfer = xf;
      if (!enable) m2_run = 0;
      else if (!m2_run) begin m2_run = 1; m2_p = 0; end
      else m2_p = (m2_p + 1) % 5;
    end
    #1;
    compare_all();
  endtask

  task automatic load(input logic [20:0] pat);
    int n;
    n = 0;
    pattern_in = pat;
    load_valid = 1'b1;
    do begin tick(); n++; end while (!m_xfer && n < 200);
    if (!m_xfer) begin
      checks++; errors++;
      $error("FAIL load_timeout: observed no transfer expected transfer within 200 cycles");
    end
    load_valid = 1'b0;
    pattern_in = 21'($urandom);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    reset = 1'b0; enable = 1'b0; load_valid = 1'b0; pattern_in = '0;
    model_reset();
    #12;
    compare_all();                       // reset state, no clock edge needed
    tick();
    reset = 1'b1;
    enable = 1'b1;

    // First frames with empty image: blank/drive cadence, frame_start every 30.
    run(2 * FR + 3);

    // Mid-frame load: held in pending until the next frame boundary.
    run(7);
    load(21'h1_4A_7F);
    run(2 * FR);

    // Back-to-back: second load waits for ready while valid is held.
    load(21'($urandom));
    load(21'($urandom));
    run(3 * FR);

    // Load exactly on the boundary edge with pending empty.
    n = 0;
    while (!(m_run && m_p == FR - 1) && n < 100) begin tick(); n++; end
    pattern_in = 21'h0A_5A5A & 21'h1F_FFFF;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    run(2 * FR + 2);

    // Drop enable during column-2 drive, then restart.
    n = 0;
    while (!(m_run && m_p / SL == 2 && m_p % SL == BL + 1) && n < 100) begin tick(); n++; end
    enable = 1'b0;
    run(5);
    load(21'($urandom));                  // loads still accepted while idle
    run(3);
    enable = 1'b1;
    run(FR + 5);

    // Randomized traffic with occasional enable drops.
    for (int i = 0; i < 600; i++) begin
      if (load_valid && m_xfer) begin
        load_valid = 1'b0;
        pattern_in = 21'($urandom);
      end else if (!load_valid) begin
        pattern_in = 21'($urandom);
        if ($urandom_range(0, 7) == 0) load_valid = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      tick();
    end
    load_valid = 1'b0;
    enable = 1'b1;

    // Async reset mid-drive with pending full.
    n = 0;
    while (!(m_run && m_p % SL == BL + 1 && !m_pfull) && n < 200) begin tick(); n++; end
    pattern_in = 21'h1F_FFFF;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_col", {27'd0, col}, 32'd0);
    check("arst_row", {25'd0, row}, 32'd0);
    check("arst_ready", {31'd0, load_ready}, 32'd1);
    check("arst_fs", {31'd0, frame_start}, 32'd0);
    model_reset();
    run(2);
    reset = 1'b1;
    run(FR + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
